// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter.
// Display fetch has absolute priority. Two writers (drawing engine, host
// loader) share the leftover cycles round-robin. Each writer is masked for
// one cycle after a grant, so the same transaction is never granted twice.
// Optional feature macro: VGA_ARB_VBLANK_ONLY_EN. When defined, writers are
// eligible only while vblank_i is high.
module vga_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vblank_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_valid_o,
  input  logic              wr0_req_i,
  input  logic [ADDR_W-1:0] wr0_addr_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  output logic              wr0_gnt_o,
  input  logic              wr1_req_i,
  input  logic [ADDR_W-1:0] wr1_addr_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  output logic              wr1_gnt_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {G_NONE, G_DISP, G_WR0, G_WR1} grant_e;

  grant_e              state_q, state_d;
  logic                rr_q, rr_d;        // 0: wr0 preferred, 1: wr1 preferred
  logic                wr_window;
  logic                elig0, elig1;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                wr0_gnt_q, wr1_gnt_q;
  logic                tag_q;
  logic                disp_valid_q;
  logic [DATA_W-1:0]   disp_rdata_q;

`ifdef VGA_ARB_VBLANK_ONLY_EN
  // Writes only during vertical blanking for tear-free updates.
  assign wr_window = vblank_i;
`else
  // vblank is ignored; writers may use any cycle the display leaves free.
  assign wr_window = vblank_i | 1'b1;
`endif

  // Next grant: display first, then eligible writers in round-robin order.
  always_comb begin
    elig0   = wr0_req_i && (state_q != G_WR0) && wr_window;
    elig1   = wr1_req_i && (state_q != G_WR1) && wr_window;
    state_d = G_NONE;
    if (disp_req_i) begin
      state_d = G_DISP;
    end else if (elig0 && elig1) begin
      state_d = rr_q ? G_WR1 : G_WR0;
    end else if (elig0) begin
      state_d = G_WR0;
    end else if (elig1) begin
      state_d = G_WR1;
    end
    rr_d = rr_q;
    if (state_d == G_WR0) rr_d = 1'b1;
    if (state_d == G_WR1) rr_d = 1'b0;
  end

  // Issue FSM with registered memory-side outputs and grant pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= G_NONE;
      rr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr0_gnt_q   <= 1'b0;
      wr1_gnt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      mem_en_q  <= (state_d != G_NONE);
      mem_we_q  <= (state_d == G_WR0) || (state_d == G_WR1);
      wr0_gnt_q <= (state_d == G_WR0);
      wr1_gnt_q <= (state_d == G_WR1);
      case (state_d)
        G_DISP: mem_addr_q <= disp_addr_i;
        G_WR0: begin
          mem_addr_q  <= wr0_addr_i;
          mem_wdata_q <= wr0_data_i;
        end
        G_WR1: begin
          mem_addr_q  <= wr1_addr_i;
          mem_wdata_q <= wr1_data_i;
        end
        default: ;  // idle: address and data hold their last value
      endcase
    end
  end

  // Read return: tag marks display reads, RAM data registered alongside.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_rdata_q <= '0;
    end else begin
      tag_q        <= (state_q == G_DISP);
      disp_valid_q <= tag_q;
      disp_rdata_q <= mem_rdata_i;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wr0_gnt_o    = wr0_gnt_q;
  assign wr1_gnt_o    = wr1_gnt_q;
  assign disp_valid_o = disp_valid_q;
  assign disp_rdata_o = disp_rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed stimulus pushes expected
// reads/writes into queues; a negedge monitor pops and compares.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 2;

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } rd_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vblank = 1'b1;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_valid;
  logic              wr0_req = 1'b0, wr1_req = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [DATA_W-1:0] wr0_data = '0, wr1_data = '0;
  logic              wr0_gnt, wr1_gnt;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  wr_t wq0[$];
  wr_t wq1[$];
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  logic [DATA_W-1:0] ram [0:1023];
  logic seen0 = 1'b0, seen1 = 1'b0;
  int   last_w_cyc = -10;
  logic last_w = 1'b0;
  int   last_wr1_cyc = 0;

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .vblank_i(vblank),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_rdata_o(disp_rdata), .disp_valid_o(disp_valid),
    .wr0_req_i(wr0_req), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data), .wr0_gnt_o(wr0_gnt),
    .wr1_req_i(wr1_req), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data), .wr1_gnt_o(wr1_gnt),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer RAM model with registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Writer models: drop/advance the request after seeing a grant
  always @(negedge clk) begin
    seen0 <= wr0_gnt;
    seen1 <= wr1_gnt;
  end

  initial forever begin
    @(posedge clk); #1;
    if (seen0 && wq0.size() > 0) void'(wq0.pop_front());
    if (wq0.size() > 0) begin
      wr0_req = 1'b1; wr0_addr = wq0[0].a; wr0_data = wq0[0].d;
    end else wr0_req = 1'b0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (seen1 && wq1.size() > 0) void'(wq1.pop_front());
    if (wq1.size() > 0) begin
      wr1_req = 1'b1; wr1_addr = wq1[0].a; wr1_data = wq1[0].d;
    end else wr1_req = 1'b0;
  end

  // Monitor: compares every display return and every RAM write
  always @(negedge clk) begin
    if (rst_n) begin
      if (disp_valid) begin
        if (exp_rd.size() == 0) chk("disp_unexpected", {31'd0, disp_valid}, 32'd0);
        else begin
          rd_t r;
          r = exp_rd.pop_front();
          chk("disp_rdata", {30'd0, disp_rdata}, {30'd0, r.d});
          chk("disp_latency", cyc, r.due);
        end
      end
      if (wr0_gnt || wr1_gnt) chk("gnt_has_we", {31'd0, mem_we & mem_en}, 32'd1);
      if (mem_en && mem_we) begin
        chk("gnt_onehot", {31'd0, wr0_gnt ^ wr1_gnt}, 32'd1);
        if (exp_wr.size() == 0) chk("wr_unexpected", {31'd0, mem_we}, 32'd0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_writer", {31'd0, wr1_gnt}, {31'd0, e.w});
          chk("wr_addr", {13'd0, mem_addr}, {13'd0, e.a});
          chk("wr_data", {30'd0, mem_wdata}, {30'd0, e.d});
        end
        if (last_w == wr1_gnt && cyc == last_w_cyc + 1)
          chk("wr_back_to_back_same", cyc, last_w_cyc + 2);
        last_w     = wr1_gnt;
        last_w_cyc = cyc;
        if (wr1_gnt) last_wr1_cyc = cyc;
      end
    end
  end

  task automatic wr_push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t t;
    t.w = w; t.a = a; t.d = d;
    if (w) wq1.push_back(t); else wq0.push_back(t);
    exp_wr.push_back(t);
  endtask

  task automatic rd_push(input logic [DATA_W-1:0] d);
    rd_t r;
    r.d = d; r.due = cyc + 3;
    exp_rd.push_back(r);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_wr.size() > 0 || exp_rd.size() > 0) && n < max_cyc) begin
      @(negedge clk); n++;
    end
    chk(name, exp_wr.size() + exp_rd.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, {mem_en, mem_we, wr0_gnt, wr1_gnt, disp_valid, disp_rdata, mem_wdata, mem_addr},
        32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 1024; i++) ram[i] = DATA_W'(i & 3);

    // Reset state
    #2 chk_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Display throughput: addresses 0..9, data = addr & 3
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(i);
      rd_push(DATA_W'(i & 3));
      @(negedge clk);
    end
    disp_req = 1'b0;
    drain("disp_drain", 10);

    // Priority: display holds off wr0 until disp_req drops
    disp_req = 1'b1;
    wr_push(1'b0, 19'h100, 2'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("prio_no_gnt", {30'd0, wr0_gnt, mem_we}, 32'd0);
      disp_addr = ADDR_W'(32 + i);
      rd_push(DATA_W'((32 + i) & 3));
      @(negedge clk);
    end
    chk("prio_no_gnt", {30'd0, wr0_gnt, mem_we}, 32'd0);
    disp_req = 1'b0;
    @(negedge clk);
    chk("prio_gnt_after_drop", {31'd0, wr0_gnt}, 32'd1);
    chk("prio_we", {31'd0, mem_we}, 32'd1);
    chk("prio_addr", {13'd0, mem_addr}, 32'h100);
    chk("prio_wdata", {30'd0, mem_wdata}, 32'd2);
    drain("prio_drain", 10);

    // Reset mid-stream (rr now points to wr1 before this reset)
    for (int i = 0; i < 5; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(4 + i);
      if (i < 3) rd_push(DATA_W'((4 + i) & 3));
      if (i == 3) begin
        #2 rst_n = 1'b0;
        exp_rd.delete();
        #1 chk_outputs_zero("midreset_outputs");
      end
      @(negedge clk);
    end
    disp_req = 1'b0;
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_valid_after_reset", {31'd0, disp_valid}, 32'd0);
    wr_push(1'b0, 19'h200, 2'd1);
    wr_push(1'b1, 19'h201, 2'd3);
    drain("reset_rr_drain", 10);

    // Round-robin: both writers streaming, grants alternate wr0,wr1,...
    wr_push(1'b0, 19'h210, 2'd0);
    wr_push(1'b1, 19'h211, 2'd1);
    wr_push(1'b0, 19'h212, 2'd2);
    wr_push(1'b1, 19'h213, 2'd3);
    wr_push(1'b0, 19'h214, 2'd1);
    wr_push(1'b1, 19'h215, 2'd2);
    drain("rr_drain", 20);

    // Single-writer mask: three wr1 transactions land at k+2, k+4, k+6
    k = cyc;
    wr_push(1'b1, 19'h220, 2'd3);
    wr_push(1'b1, 19'h221, 2'd2);
    wr_push(1'b1, 19'h222, 2'd1);
    drain("mask_drain", 20);
    chk("mask_last_write_cycle", last_wr1_cyc, k + 6);
    repeat (3) @(negedge clk);

`ifdef VGA_ARB_VBLANK_ONLY_EN
    // Writes held off during active video, granted once vblank rises
    vblank = 1'b0;
    wr_push(1'b0, 19'h230, 2'd2);
    repeat (4) begin
      @(negedge clk);
      chk("vblank_hold", {31'd0, wr0_gnt}, 32'd0);
    end
    vblank = 1'b1;
    @(negedge clk);
    chk("vblank_gnt", {31'd0, wr0_gnt}, 32'd1);
    drain("vblank_drain", 10);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA pixel fetch path and two pixel writers (drawing engine, host loader). Display fetch has absolute priority so scan-out never stalls. Writers share leftover cycles by round-robin. Sits between the VGA timing/pixel pipeline and the framebuffer RAM; its read data feeds the 2-bit colour input of the VGA output stage.

## Interface
- ADDR_W, 19, framebuffer word address width (640x480 = 307200 words)
- DATA_W, 2, pixel width (matches 2-bit colour input of VGA output stage)
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking, from VGA timing
- disp_req  in  1  display fetch request, one read per cycle
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  fetched pixel
- disp_valid  out  1  disp_rdata valid
- wr0_req / wr1_req  in  1  writer request, held until granted
- wr0_addr / wr1_addr  in  ADDR_W  write address, stable while req high
- wr0_data / wr1_data  in  DATA_W  write data, stable while req high
- wr0_gnt / wr1_gnt  out  1  one-cycle grant pulse
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- Issue FSM, one state per cycle, registered: G_NONE, G_DISP, G_WR0, G_WR1. State = access issued on mem_* this cycle.
- Next-state decision, from inputs sampled at edge:
  - disp_req=1 -> G_DISP, regardless of writers.
  - else eligible writers = req high and not granted in current state (mask of just-granted writer).
  - both eligible -> writer indicated by rr pointer; one eligible -> that writer; none -> G_NONE.
- rr pointer: after granting wrN, points to the other writer. Reset value: wr0.
- G_DISP: mem_en=1, mem_we=0, mem_addr=registered disp_addr.
- G_WRn: mem_en=1, mem_we=1, mem_addr/mem_wdata=registered wrN_addr/data, wrN_gnt=1.
- G_NONE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last value.
- Writer rule: on seeing wrN_gnt high at a rising edge, writer drops req or presents the next transaction. The one-cycle mask prevents double-granting the same transaction. A single writer therefore gets at most one write every two cycles.
- Read return: a 1-bit tag pipeline marks display reads. disp_rdata registers mem_rdata, and disp_valid is the tag delayed.
- No address range check; out-of-range addresses pass through unchanged.
- Writer never preempts display; writer starvation during active video is by design.

## Timing
- Reset (rst=0, asynchronous): state G_NONE, all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, wr0_gnt, wr1_gnt, disp_valid, disp_rdata), rr=wr0, tag pipeline cleared. In-flight reads are discarded, with no disp_valid after reset release.
- Display latency: disp_req sampled at edge E -> mem_en at E+1 -> mem_rdata at E+2 -> disp_valid/disp_rdata at E+3. Fixed 3 cycles, fully pipelined, one pixel per cycle.
- Write: req sampled at edge E -> mem_we and wrN_gnt high in cycle after E (both valid at edge E+1).
- Simultaneous events:
  - disp_req plus both writers -> display.
  - Both writers, no display -> rr order.
  - disp_req drop while a writer is pending -> writer issued the next cycle.
- Back-to-back: display may be granted every cycle. Writers alternate every cycle when both are requesting.

## Configuration
- VGA_ARB_VBLANK_ONLY_EN:
  - Defined: a writer is eligible only when vblank=1, in addition to the rules above. Writes during active video, including horizontal blanking, are held off, giving tear-free updates.
  - Undefined: writers are eligible whenever disp_req=0, vblank is ignored.

## Test plan
- Reset mid-stream: disp_req=1 for 5 cycles, rst=0 at cycle 3 -> all outputs 0 immediately, no disp_valid after release, next grant to wr0 when both writers request.
- Display throughput: disp_req=1 with addresses 0..9, RAM preloaded addr&3 -> disp_valid at cycles 3..12, disp_rdata 0,1,2,3,0,1,…
- Priority: disp_req=1 and wr0_req=1 (addr 0x100, data 2) for 4 cycles, then disp_req=0 -> wr0_gnt in the cycle after disp_req drops, mem_addr=0x100, mem_wdata=2, mem_we=1.
- Round-robin: wr0 and wr1 requesting continuously, disp_req=0 -> grants alternate wr0,wr1,wr0,wr1, never two consecutive grants to the same writer.
- Single-writer mask: only wr1_req held high with 3 queued transactions -> wr1_gnt on every other cycle, 3 writes in 6 cycles, no duplicate write.
- Macro on: VGA_ARB_VBLANK_ONLY_EN defined, vblank=0, disp_req=0, wr0_req=1 -> no grant. Raise vblank=1 -> wr0_gnt the following cycle.
